// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad encoder: FSM state encoding and the
// "no key" code helper.
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_REPEAT  = 2'd2
   } kp_state_e;

   // All-ones code of the requested width (callers size-cast the result).
   function automatic logic [31:0] no_key(input int unsigned code_w);
      no_key = 32'hFFFF_FFFF >> (32 - code_w);
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Two-flop synchroniser followed by a whole-vector debouncer: the debounced
// vector only follows a synchronised value held for DEBOUNCE_CYCLES samples.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int N_KEYS          = 10,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [N_KEYS-1:0] keypad_i,
   output logic [N_KEYS-1:0] debounced_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] sync1_q;
   logic [N_KEYS-1:0] sync2_q;
   logic [N_KEYS-1:0] stable_q;
   logic [N_KEYS-1:0] stable_d;
   logic [N_KEYS-1:0] cand_q;
   logic [N_KEYS-1:0] cand_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   // Synchroniser, debounced vector and candidate counter registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cand_q   <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= keypad_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
      end
   end

   // cnt_q holds how many consecutive samples of cand_q have been seen so far.
   always_comb begin
      stable_d = stable_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         if (DEBOUNCE_CYCLES <= 1) begin
            stable_d = sync2_q;
            cnt_d    = '0;
         end else begin
            cnt_d = CNT_W'(1);
         end
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign debounced_o = stable_q;

endmodule

// File: rtl/keypad_encoder_sync.sv
// Debounced priority keypad encoder with key strobe and auto-repeat.
// All outputs are registered one edge after the debounced vector.
module keypad_encoder_sync
   import keypad_pkg::*;
#(
   parameter int N_KEYS          = 10,
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 20,
   parameter int REPEAT_RATE     = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enablen,
   input  logic [N_KEYS-1:0] keypad,
   output logic [CODE_W-1:0] D,
   output logic              valid,
   output logic              key_strobe,
   output logic              multi
);

   localparam logic [CODE_W-1:0] NO_KEY = CODE_W'(no_key(CODE_W));
   localparam int T_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TMR_W = $clog2(T_MAX + 1);
   localparam logic [TMR_W-1:0] DELAY_END = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] RATE_END  = TMR_W'(REPEAT_RATE - 1);

   logic [N_KEYS-1:0] deb_s;
   logic [CODE_W-1:0] code_s;
   logic              any_s;
   logic              multi_s;
   logic [TMR_W-1:0]  timer_inc_s;

   kp_state_e         state_q;
   kp_state_e         state_d;
   logic [TMR_W-1:0]  timer_q;
   logic [TMR_W-1:0]  timer_d;
   logic [CODE_W-1:0] d_q;
   logic [CODE_W-1:0] d_d;
   logic              valid_q;
   logic              valid_d;
   logic              strobe_q;
   logic              strobe_d;
   logic              multi_q;
   logic              multi_d;

   keypad_debounce #(
      .N_KEYS          (N_KEYS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk         (clk),
      .resetn      (resetn),
      .keypad_i    (keypad),
      .debounced_o (deb_s)
   );

   // Lowest set index wins; scanning downward leaves the lowest one last.
   always_comb begin
      code_s = NO_KEY;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         code_s = deb_s[i] ? CODE_W'(i) : code_s;
      end
   end

   assign any_s       = |deb_s;
   assign multi_s     = |(deb_s & (deb_s - N_KEYS'(1)));
   assign timer_inc_s = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);

   // Strobe FSM and output next-state; d_q holds the code currently reported.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      d_d      = NO_KEY;
      valid_d  = 1'b0;
      strobe_d = 1'b0;
      multi_d  = 1'b0;
      if (enablen) begin
         state_d = ST_IDLE;
         timer_d = '0;
      end else begin
         d_d     = code_s;
         valid_d = any_s;
         multi_d = multi_s;
         case (state_q)
            ST_IDLE: begin
               if (any_s) begin
                  state_d  = ST_PRESSED;
                  strobe_d = 1'b1;
                  timer_d  = '0;
               end else begin
                  timer_d = '0;
               end
            end
            ST_PRESSED, ST_REPEAT: begin
               if (!any_s) begin
                  state_d = ST_IDLE;
                  timer_d = '0;
               end else if (code_s != d_q) begin
                  state_d  = ST_PRESSED;
                  strobe_d = 1'b1;
                  timer_d  = '0;
               end else if ((state_q == ST_PRESSED) && (REPEAT_DELAY != 0) &&
                            (timer_q == DELAY_END)) begin
                  state_d  = ST_REPEAT;
                  strobe_d = 1'b1;
                  timer_d  = '0;
               end else if ((state_q == ST_REPEAT) && (timer_q == RATE_END)) begin
                  strobe_d = 1'b1;
                  timer_d  = '0;
               end else begin
                  timer_d = timer_inc_s;
               end
            end
            default: begin
               state_d = ST_IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // FSM, repeat timer and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         d_q      <= NO_KEY;
         valid_q  <= 1'b0;
         strobe_q <= 1'b0;
         multi_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         d_q      <= d_d;
         valid_q  <= valid_d;
         strobe_q <= strobe_d;
         multi_q  <= multi_d;
      end
   end

   assign D          = d_q;
   assign valid      = valid_q;
   assign key_strobe = strobe_q;
   assign multi      = multi_q;

endmodule

// File: tb/tb_keypad_encoder_sync.sv
// Randomised scoreboard bench for keypad_encoder_sync with a cycle-level
// reference model built from input history and strobe timing rules.
module tb_keypad_encoder_sync;

   localparam int NK = 10;
   localparam int CW = 4;
   localparam int DC = 4;
   localparam int RD = 20;
   localparam int RR = 8;
   localparam logic [CW-1:0] TB_NO_KEY = 4'hF;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          enablen;
   logic [NK-1:0] keypad;
   logic [CW-1:0] D;
   logic          valid;
   logic          key_strobe;
   logic          multi;

   logic          rn2;
   logic          en2;
   logic [14:0]   kp2;
   logic [3:0]    d2;
   logic          v2;
   logic          ks2;
   logic          m2;

   keypad_encoder_sync #(
      .N_KEYS(NK), .CODE_W(CW), .DEBOUNCE_CYCLES(DC),
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .resetn(resetn), .enablen(enablen), .keypad(keypad),
      .D(D), .valid(valid), .key_strobe(key_strobe), .multi(multi)
   );

   keypad_encoder_sync #(
      .N_KEYS(15), .CODE_W(4), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(0), .REPEAT_RATE(8)
   ) dut2 (
      .clk(clk), .resetn(rn2), .enablen(en2), .keypad(kp2),
      .D(d2), .valid(v2), .key_strobe(ks2), .multi(m2)
   );

   typedef struct {
      int            cyc;
      logic [CW-1:0] d;
      logic          v;
      logic          m;
   } lvl_t;

   typedef struct {
      int            cyc;
      logic [CW-1:0] d;
      logic          m;
   } ev_t;

   lvl_t lvl_q[$];
   ev_t  ev_q[$];
   int   total = 0;
   int   bad   = 0;
   int   scyc  = 0;
   int   mcyc  = 0;

   // reference model state
   logic [NK-1:0] hist [0:15];
   logic [NK-1:0] mdeb;
   logic          pv;
   logic [CW-1:0] pc;
   int            since;
   int            reps;

   // One rising edge of the reference: outputs come from the previous
   // debounced value, then the debounced value follows DC equal samples
   // of the input as seen two edges late.
   task automatic model_edge(input logic rn, input logic en, input logic [NK-1:0] kp);
      lvl_t l;
      ev_t  e;
      int   code;
      int   cnt;
      logic st;
      logic same;
      l.cyc = scyc;
      st    = 1'b0;
      if (!rn) begin
         for (int j = 0; j < 16; j++) hist[j] = '0;
         mdeb  = '0;
         pv    = 1'b0;
         since = 0;
         reps  = 0;
         l.d = TB_NO_KEY; l.v = 1'b0; l.m = 1'b0;
      end else begin
         cnt  = 0;
         code = -1;
         for (int i = NK - 1; i >= 0; i--) begin
            if (mdeb[i]) begin
               code = i;
               cnt++;
            end
         end
         if (en || code < 0) begin
            l.d = TB_NO_KEY; l.v = 1'b0; l.m = 1'b0;
            pv  = 1'b0;
         end else begin
            l.d = CW'(code); l.v = 1'b1; l.m = (cnt >= 2);
            if (!pv || pc != CW'(code)) begin
               st = 1'b1; since = 0; reps = 0;
            end else begin
               since++;
               if ((reps == 0) ? (RD > 0 && since == RD) : (since == RR)) begin
                  st = 1'b1; since = 0; reps++;
               end
            end
            pv = 1'b1;
            pc = CW'(code);
         end
         for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = kp;
         same = 1'b1;
         for (int j = 3; j <= DC + 1; j++) begin
            if (hist[j] != hist[2]) same = 1'b0;
         end
         if (same) mdeb = hist[2];
      end
      lvl_q.push_back(l);
      if (st) begin
         e.cyc = scyc; e.d = l.d; e.m = l.m;
         ev_q.push_back(e);
      end
   endtask

   task automatic step(input logic rn, input logic en, input logic [NK-1:0] kp);
      resetn  = rn;
      enablen = en;
      keypad  = kp;
      scyc++;
      model_edge(rn, en, kp);
      @(posedge clk);
      #2;
   endtask

   task automatic hold(input int n, input logic rn, input logic en, input logic [NK-1:0] kp);
      for (int c = 0; c < n; c++) step(rn, en, kp);
   endtask

   lvl_t mon_l;
   ev_t  mon_e;

   // Monitor: level check every edge, strobe events checked against the queue.
   always @(posedge clk) begin
      #1;
      mcyc++;
      if (lvl_q.size() > 0) begin
         mon_l = lvl_q.pop_front();
         total++;
         if (mon_l.cyc != mcyc || D !== mon_l.d || valid !== mon_l.v || multi !== mon_l.m) begin
            bad++;
            $display("FAIL level edge=%0d: got D=%0d valid=%0b multi=%0b, want D=%0d valid=%0b multi=%0b (tag %0d)",
                     mcyc, D, valid, multi, mon_l.d, mon_l.v, mon_l.m, mon_l.cyc);
         end
      end
      while (ev_q.size() > 0 && ev_q[0].cyc < mcyc) begin
         mon_e = ev_q.pop_front();
         total++;
         bad++;
         $display("FAIL missed_strobe: expected strobe at edge %0d, key_strobe stayed low (now %0d)", mon_e.cyc, mcyc);
      end
      if (key_strobe !== 1'b0) begin
         total++;
         if (ev_q.size() == 0 || ev_q[0].cyc != mcyc) begin
            bad++;
            $display("FAIL unexpected_strobe: key_strobe=%b at edge %0d, no strobe expected", key_strobe, mcyc);
         end else begin
            mon_e = ev_q.pop_front();
            if (D !== mon_e.d || multi !== mon_e.m) begin
               bad++;
               $display("FAIL strobe_data edge=%0d: got D=%0d multi=%0b, want D=%0d multi=%0b",
                        mcyc, D, multi, mon_e.d, mon_e.m);
            end
         end
      end
   end

   logic [NK-1:0] rkp;
   int            sel;
   int            hl;
   logic          ren;
   logic          rrn;
   int            n2;
   int            first2;

   initial begin
      rn2 = 1'b0; en2 = 1'b0; kp2 = '0;
      hold(3, 1'b0, 1'b0, '0);
      // press key 3 with repeats, then release
      hold(50, 1'b1, 1'b0, 10'b0000001000);
      hold(12, 1'b1, 1'b0, '0);
      // two keys, then lower one released
      hold(15, 1'b1, 1'b0, 10'b0000100100);
      hold(15, 1'b1, 1'b0, 10'b0000100000);
      hold(10, 1'b1, 1'b0, '0);
      // short glitch on key 9
      hold(3, 1'b1, 1'b0, 10'b1000000000);
      hold(10, 1'b1, 1'b0, '0);
      // disable while key 4 held
      hold(10, 1'b1, 1'b0, 10'b0000010000);
      hold(5, 1'b1, 1'b1, 10'b0000010000);
      hold(5, 1'b1, 1'b0, 10'b0000010000);
      hold(10, 1'b1, 1'b0, '0);
      // reset in the middle of auto-repeat
      hold(40, 1'b1, 1'b0, 10'b0000001000);
      hold(2, 1'b0, 1'b0, 10'b0000001000);
      hold(15, 1'b1, 1'b0, 10'b0000001000);
      hold(10, 1'b1, 1'b0, '0);
      // randomised phase
      for (int b = 0; b < 80; b++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0: rkp = '0;
            1, 2, 3, 4: rkp = NK'(1) << $urandom_range(0, NK - 1);
            5, 6: rkp = (NK'(1) << $urandom_range(0, NK - 1)) | (NK'(1) << $urandom_range(0, NK - 1));
            default: rkp = NK'($urandom);
         endcase
         hl  = $urandom_range(1, 40);
         ren = ($urandom_range(0, 9) == 0);
         rrn = ($urandom_range(0, 19) != 0);
         for (int c = 0; c < hl; c++) step((c < 2) ? rrn : 1'b1, ren, rkp);
      end
      hold(3, 1'b0, 1'b0, '0);
      total++;
      if (ev_q.size() != 0 || lvl_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: %0d strobe and %0d level entries left, want 0", ev_q.size(), lvl_q.size());
      end

      // 15-key instance with auto-repeat disabled: key 14 gives one strobe
      n2 = 0;
      first2 = 0;
      rn2 = 1'b1;
      kp2 = 15'h4000;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (ks2 !== 1'b0) begin
            n2++;
            if (n2 == 1) first2 = c;
         end
         if (c == 6) begin
            total++;
            if (v2 !== 1'b0 || d2 !== 4'hF) begin
               bad++;
               $display("FAIL nk15_early: got valid=%b D=%0d at edge 6, want valid=0 D=15", v2, d2);
            end
         end
         if (c == 7) begin
            total++;
            if (v2 !== 1'b1 || d2 !== 4'd14 || m2 !== 1'b0) begin
               bad++;
               $display("FAIL nk15_code: got valid=%b D=%0d multi=%b, want valid=1 D=14 multi=0", v2, d2, m2);
            end
         end
      end
      total++;
      if (n2 != 1 || first2 != 7) begin
         bad++;
         $display("FAIL nk15_strobes: got %0d strobes first at edge %0d, want 1 at edge 7", n2, first2);
      end
      total++;
      if (d2 !== 4'd14 || v2 !== 1'b1) begin
         bad++;
         $display("FAIL nk15_hold: got D=%0d valid=%b after 60 edges, want D=14 valid=1", d2, v2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
